// File: rtl/inert_pkg.sv
// Shared types and helpers for the inertial-sensor SPI front end.
package inert_pkg;

    typedef enum logic [2:0] {
        PWR_UP,
        INIT,
        WAIT_INT,
        READ,
        DRAIN,
        FLUSH
    } state_t;

    localparam logic READ_BIT = 1'b1;

    // Sensor read command: read flag, register address, don't-care data byte.
    function automatic logic [15:0] rd_cmd(input logic [6:0] addr7);
        return {READ_BIT, addr7, 8'h00};
    endfunction

endpackage

// File: rtl/SPI_mstr16.sv
// 16-bit SPI master, mode 0 (SCLK idles low), SCLK = clk/4.
// MOSI launched on SCLK fall, MISO sampled ahead of SCLK rise.
module SPI_mstr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done,
    output logic [15:0] rd_data
);

    logic        active;
    logic [1:0]  div;
    logic [3:0]  bit_cnt;
    logic [15:0] shft;
    logic        miso_s;

    // Transfer sequencing: load on wrt, shift one bit per SCLK period, done after 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active  <= 1'b0;
            SS_n    <= 1'b1;
            div     <= '0;
            bit_cnt <= '0;
            shft    <= '0;
            miso_s  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (wrt) begin
                    active  <= 1'b1;
                    SS_n    <= 1'b0;
                    shft    <= cmd;
                    div     <= '0;
                    bit_cnt <= '0;
                end
            end else begin
                div <= div + 2'd1;
                if (div == 2'd1)
                    miso_s <= MISO;
                if (div == 2'd3) begin
                    shft    <= {shft[14:0], miso_s};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        active <= 1'b0;
                        SS_n   <= 1'b1;
                        done   <= 1'b1;
                    end
                end
            end
        end
    end

    assign SCLK    = active & div[1];
    assign MOSI    = shft[15];
    assign rd_data = shft;

endmodule

// File: rtl/inert_mchan_intf.sv
// Multi-channel SPI inertial-sensor front end: power-up delay, init writes,
// INT-triggered pipelined burst reads, atomic sample presentation.
module inert_mchan_intf
    import inert_pkg::*;
#(
    parameter int unsigned              NUM_CH      = 2,
    parameter int unsigned              INIT_CNT    = 3,
    parameter logic [INIT_CNT*16-1:0]   INIT_CMDS   = {16'h1460, 16'h1150, 16'h1053},
    parameter logic [NUM_CH*7-1:0]      CH_ADDR     = {7'h2C, 7'h22},
    parameter int unsigned              PWR_UP_BITS = 16,
    parameter int unsigned              TO_CYC      = 2_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   INT,
    input  logic                   MISO,
    output logic                   SS_n,
    output logic                   SCLK,
    output logic                   MOSI,
    output logic                   init_done,
    output logic                   vld,
    output logic [NUM_CH*16-1:0]   data,
    output logic                   err_to,
    output logic [7:0]             ovr_cnt
);

    localparam int unsigned NB   = 2 * NUM_CH;
    localparam int unsigned TO_W = $clog2(TO_CYC + 1);

    state_t                   state, state_nxt;
    logic [PWR_UP_BITS-1:0]   pwr_cnt;
    logic [3:0]               init_idx;
    logic [4:0]               byte_idx;
    logic [4:0]               cap_idx;
    logic [TO_W-1:0]          to_cnt;
    logic                     int_meta, INT_s, INT_s_d, int_rise;
    logic [NUM_CH*16-1:0]     shadow;

    logic                     wrt, spi_done;
    logic [15:0]              cmd, spi_rd;
    logic                     init_adv, init_fin, burst_go, byte_adv, cap, flush_done;

    // Byte b of the burst: channel b>>1, low byte at CH_ADDR, high byte at CH_ADDR+1.
    function automatic logic [15:0] byte_cmd(input logic [4:0] b);
        int unsigned ch;
        ch = int'(b >> 1);
        return rd_cmd(CH_ADDR[7*ch +: 7] + {6'd0, b[0]});
    endfunction

    SPI_mstr16 u_spi (
        .clk     (clk),
        .rst_n   (~rst),
        .wrt     (wrt),
        .cmd     (cmd),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .done    (spi_done),
        .rd_data (spi_rd)
    );

    assign int_rise = INT_s & ~INT_s_d;
    assign cap_idx  = byte_idx - 5'd1;

    // INT synchroniser plus one delayed copy for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_meta <= 1'b0;
            INT_s    <= 1'b0;
            INT_s_d  <= 1'b0;
        end else begin
            int_meta <= INT;
            INT_s    <= int_meta;
            INT_s_d  <= INT_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= PWR_UP;
        else     state <= state_nxt;
    end

    // Next state and SPI command issue. Replies run one transfer behind the
    // command that requested them, so capture lags issue by one byte and two
    // trailing transfers (last byte, dummy) drain the pipeline.
    always_comb begin
        state_nxt  = state;
        wrt        = 1'b0;
        cmd        = '0;
        init_adv   = 1'b0;
        init_fin   = 1'b0;
        burst_go   = 1'b0;
        byte_adv   = 1'b0;
        cap        = 1'b0;
        flush_done = 1'b0;
        case (state)
            PWR_UP: if (&pwr_cnt) begin
                wrt       = 1'b1;
                cmd       = INIT_CMDS[15:0];
                state_nxt = INIT;
            end
            INIT: if (spi_done) begin
                if (init_idx < 4'(INIT_CNT - 1)) begin
                    wrt      = 1'b1;
                    cmd      = INIT_CMDS[16*(int'(init_idx) + 1) +: 16];
                    init_adv = 1'b1;
                end else begin
                    init_fin  = 1'b1;
                    state_nxt = WAIT_INT;
                end
            end
            WAIT_INT: if (INT_s) begin
                wrt       = 1'b1;
                cmd       = byte_cmd(5'd0);
                burst_go  = 1'b1;
                state_nxt = READ;
            end
            READ: if (spi_done) begin
                cap      = (byte_idx != 5'd0);
                wrt      = 1'b1;
                cmd      = byte_cmd(byte_idx + 5'd1);
                byte_adv = 1'b1;
                if (byte_idx + 5'd1 == 5'(NB - 1))
                    state_nxt = DRAIN;
            end
            DRAIN: if (spi_done) begin
                cap       = 1'b1;
                wrt       = 1'b1;
                cmd       = byte_cmd(5'd0);
                byte_adv  = 1'b1;
                state_nxt = FLUSH;
            end
            FLUSH: if (spi_done) begin
                flush_done = 1'b1;
                state_nxt  = WAIT_INT;
            end
            default: state_nxt = PWR_UP;
        endcase
    end

    // Power-up, init-index, burst-byte and INT-timeout counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwr_cnt   <= '0;
            init_idx  <= '0;
            byte_idx  <= '0;
            to_cnt    <= '0;
            init_done <= 1'b0;
            err_to    <= 1'b0;
        end else begin
            if (state == PWR_UP)
                pwr_cnt <= pwr_cnt + PWR_UP_BITS'(1);
            if (init_adv)
                init_idx <= init_idx + 4'd1;
            if (init_fin)
                init_done <= 1'b1;
            if (burst_go)
                byte_idx <= '0;
            else if (byte_adv)
                byte_idx <= byte_idx + 5'd1;
            if (state == WAIT_INT) begin
                if (to_cnt == TO_W'(TO_CYC - 1))
                    err_to <= 1'b1;
                if (INT_s)
                    to_cnt <= '0;
                else if (to_cnt != TO_W'(TO_CYC - 1))
                    to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    // Shadow capture, atomic output update with vld, and overrun counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            data    <= '0;
            vld     <= 1'b0;
            ovr_cnt <= '0;
        end else begin
            vld <= flush_done;
            if (cap)
                shadow[8*int'(cap_idx) +: 8] <= spi_rd[7:0];
            if (flush_done)
                data <= {spi_rd[7:0], shadow[NUM_CH*16-9:0]};
            if (int_rise && (state inside {READ, DRAIN, FLUSH}) && ovr_cnt != 8'hFF)
                ovr_cnt <= ovr_cnt + 8'd1;
        end
    end

endmodule
